// File: rtl/sys_irq_ctrl_pkg.sv
// sys_irq_ctrl_pkg: register addresses and bit positions shared by the
// interrupt aggregator and its priority encoder.
package sys_irq_ctrl_pkg;
   localparam logic [2:0] ADDR_STATUS  = 3'd0;
   localparam logic [2:0] ADDR_PENDING = 3'd1;
   localparam logic [2:0] ADDR_MASK    = 3'd2;
   localparam logic [2:0] ADDR_MODE    = 3'd3;
   localparam logic [2:0] ADDR_VECTOR  = 3'd4;
   localparam logic [2:0] ADDR_SWTRIG  = 3'd5;
   localparam logic [2:0] ADDR_CTRL    = 3'd6;
   localparam int VEC_ANY_BIT = 15;
   localparam int CTRL_EN_BIT = 0;
   localparam int MAX_SRC     = 16;
endpackage

// File: rtl/sys_irq_ctrl_prio_enc.sv
// sys_irq_ctrl_prio_enc: combinational lowest-set-bit encoder over 16 lines,
// returning the winning index and an any-set flag.
module sys_irq_ctrl_prio_enc
   import sys_irq_ctrl_pkg::*;
(
   input  logic [MAX_SRC-1:0] i_vec,
   output logic [3:0]         o_idx,
   output logic               o_any
);
   always_comb begin
      o_idx = '0;
      for (int i = MAX_SRC - 1; i >= 0; i--) if (i_vec[i]) o_idx = 4'(i);
   end
   assign o_any = |i_vec;
endmodule

// File: rtl/sys_irq_ctrl.sv
// sys_irq_ctrl: level/edge interrupt aggregator with pending, mask, mode and
// global enable registers on an Avalon-MM slave, driving one registered irq.
module sys_irq_ctrl
   import sys_irq_ctrl_pkg::*;
#(
   parameter int N_SRC = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_SRC-1:0] irq_in,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [15:0]      writedata,
   output logic [15:0]      readdata,
   output logic             irq
);
   logic [N_SRC-1:0] r_pending, r_mask, r_mode, r_prev;
   logic             r_en;
   logic             w_wr;
   logic [N_SRC-1:0] w_wdata, w_w1c, w_sw, w_mode_chg, w_edge_nxt, w_status;
   logic [3:0]       w_idx;
   logic             w_any;
   logic [15:0]      w_vector, w_rdata;

   assign w_wr       = chipselect & ~write_n;
   assign w_wdata    = N_SRC'(writedata);
   assign w_w1c      = (w_wr && address == ADDR_PENDING) ? w_wdata : '0;
   assign w_sw       = (w_wr && address == ADDR_SWTRIG) ? w_wdata : '0;
   assign w_mode_chg = (w_wr && address == ADDR_MODE) ? (w_wdata ^ r_mode) : '0;
   // set terms are OR-ed after the clear so a racing event is never lost
   assign w_edge_nxt = (irq_in & ~r_prev) | w_sw | (r_pending & ~w_w1c);
   assign w_status   = r_pending & r_mask;

   sys_irq_ctrl_prio_enc u_prio (
      .i_vec (16'(w_status)),
      .o_idx (w_idx),
      .o_any (w_any)
   );

   always_comb begin
      w_vector = '0;
      w_vector[VEC_ANY_BIT] = w_any;
      w_vector[3:0] = w_idx;
      w_rdata = (address == ADDR_STATUS)  ? 16'(w_status)  :
                (address == ADDR_PENDING) ? 16'(r_pending) :
                (address == ADDR_MASK)    ? 16'(r_mask)    :
                (address == ADDR_MODE)    ? 16'(r_mode)    :
                (address == ADDR_VECTOR)  ? w_vector       :
                (address == ADDR_CTRL)    ? 16'(r_en)      : '0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pending <= '0;
         r_mask    <= '0;
         r_mode    <= '0;
         r_prev    <= '0;
         r_en      <= 1'b0;
         readdata  <= '0;
         irq       <= 1'b0;
      end else begin
         r_prev    <= irq_in;
         r_pending <= ((r_mode & w_edge_nxt) | (~r_mode & irq_in)) & ~w_mode_chg;
         if (w_wr && address == ADDR_MASK) r_mask <= w_wdata;
         if (w_wr && address == ADDR_MODE) r_mode <= w_wdata;
         if (w_wr && address == ADDR_CTRL) r_en <= writedata[CTRL_EN_BIT];
         readdata  <= w_rdata;
         irq       <= r_en & |w_status;
      end
   end
endmodule

// File: tb/tb_sys_irq_ctrl.sv
// tb_sys_irq_ctrl: directed vector table, async-reset sequence and random
// traffic, all checked against a behavioural model of the register rules.
module tb_sys_irq_ctrl;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  irq_in = '0;
   logic [2:0]  address = '0;
   logic        chipselect = 1'b0;
   logic        write_n = 1'b1;
   logic [15:0] writedata = '0;
   logic [15:0] readdata;
   logic        irq;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0] m_pend, m_mask, m_mode, m_prev;
   bit         m_en;

   typedef struct {
      logic [2:0]  a;
      bit          wr;
      logic [15:0] wd;
      logic [7:0]  iv;
      logic [15:0] rd;
      bit          irq;
   } vec_t;
   vec_t tv[$];

   sys_irq_ctrl #(.N_SRC(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .irq_in     (irq_in),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .irq        (irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] vec_of(input logic [7:0] s);
      for (int i = 0; i < 8; i++) if (s[i]) return 16'h8000 | 16'(i);
      return 16'h0000;
   endfunction

   function automatic logic [15:0] model_read(input logic [2:0] a);
      case (a)
         3'd0: return {8'h00, m_pend & m_mask};
         3'd1: return {8'h00, m_pend};
         3'd2: return {8'h00, m_mask};
         3'd3: return {8'h00, m_mode};
         3'd4: return vec_of(m_pend & m_mask);
         3'd6: return {15'h0, m_en};
         default: return 16'h0000;
      endcase
   endfunction

   task automatic model_reset();
      m_pend = '0; m_mask = '0; m_mode = '0; m_prev = '0; m_en = 0;
   endtask

   // one bus cycle: drive, clock, then compare DUT against the model
   task automatic step(input logic [2:0] a, input bit cs, input bit wn,
                       input logic [15:0] wd, input logic [7:0] iv, input string tag);
      bit          wr;
      logic [15:0] exp_rd;
      bit          exp_irq;
      logic [7:0]  np;
      wr = cs && !wn;
      address = a; chipselect = cs; write_n = wn; writedata = wd; irq_in = iv;
      exp_rd  = model_read(a);
      exp_irq = m_en && ((m_pend & m_mask) != 0);
      for (int i = 0; i < 8; i++) begin
         if (wr && a == 3'd3 && wd[i] != m_mode[i]) np[i] = 1'b0;
         else if (!m_mode[i]) np[i] = iv[i];
         else if ((iv[i] && !m_prev[i]) || (wr && a == 3'd5 && wd[i])) np[i] = 1'b1;
         else if (wr && a == 3'd1 && wd[i]) np[i] = 1'b0;
         else np[i] = m_pend[i];
      end
      @(posedge clk);
      #1;
      m_pend = np;
      m_prev = iv;
      if (wr && a == 3'd2) m_mask = wd[7:0];
      if (wr && a == 3'd3) m_mode = wd[7:0];
      if (wr && a == 3'd6) m_en = wd[0];
      check({tag, " model rd"}, readdata, exp_rd);
      check({tag, " model irq"}, {15'h0, irq}, {15'h0, exp_irq});
   endtask

   initial begin
      tv.push_back('{3'd2, 1, 16'h0001, 8'h00, 16'h0000, 0});
      tv.push_back('{3'd6, 1, 16'h0001, 8'h00, 16'h0000, 0});
      tv.push_back('{3'd4, 0, 16'h0000, 8'h01, 16'h0000, 0});
      tv.push_back('{3'd4, 0, 16'h0000, 8'h01, 16'h8000, 1});
      tv.push_back('{3'd4, 0, 16'h0000, 8'h01, 16'h8000, 1});
      tv.push_back('{3'd4, 0, 16'h0000, 8'h01, 16'h8000, 1});
      tv.push_back('{3'd4, 0, 16'h0000, 8'h01, 16'h8000, 1});
      tv.push_back('{3'd4, 0, 16'h0000, 8'h00, 16'h8000, 1});
      tv.push_back('{3'd4, 0, 16'h0000, 8'h00, 16'h0000, 0});
      tv.push_back('{3'd2, 1, 16'h0000, 8'h00, 16'h0001, 0});
      tv.push_back('{3'd3, 1, 16'h0004, 8'h00, 16'h0000, 0});
      tv.push_back('{3'd2, 1, 16'h0004, 8'h00, 16'h0000, 0});
      tv.push_back('{3'd1, 0, 16'h0000, 8'h04, 16'h0000, 0});
      tv.push_back('{3'd1, 0, 16'h0000, 8'h00, 16'h0004, 1});
      tv.push_back('{3'd1, 0, 16'h0000, 8'h00, 16'h0004, 1});
      tv.push_back('{3'd1, 1, 16'h0004, 8'h04, 16'h0004, 1});
      tv.push_back('{3'd1, 0, 16'h0000, 8'h00, 16'h0004, 1});
      tv.push_back('{3'd1, 1, 16'h0004, 8'h00, 16'h0004, 1});
      tv.push_back('{3'd1, 0, 16'h0000, 8'h00, 16'h0000, 0});
      tv.push_back('{3'd3, 1, 16'h008A, 8'h00, 16'h0004, 0});
      tv.push_back('{3'd2, 1, 16'h008A, 8'h00, 16'h0004, 0});
      tv.push_back('{3'd4, 0, 16'h0000, 8'h8A, 16'h0000, 0});
      tv.push_back('{3'd4, 0, 16'h0000, 8'h00, 16'h8001, 1});
      tv.push_back('{3'd1, 1, 16'h0002, 8'h00, 16'h008A, 1});
      tv.push_back('{3'd4, 0, 16'h0000, 8'h00, 16'h8003, 1});
      tv.push_back('{3'd1, 1, 16'h0008, 8'h00, 16'h0088, 1});
      tv.push_back('{3'd4, 0, 16'h0000, 8'h00, 16'h8007, 1});
      tv.push_back('{3'd1, 1, 16'h0080, 8'h00, 16'h0080, 1});
      tv.push_back('{3'd3, 1, 16'h0010, 8'h00, 16'h008A, 0});
      tv.push_back('{3'd2, 1, 16'h0000, 8'h00, 16'h008A, 0});
      tv.push_back('{3'd6, 1, 16'h0000, 8'h10, 16'h0001, 0});
      tv.push_back('{3'd0, 0, 16'h0000, 8'h00, 16'h0000, 0});
      tv.push_back('{3'd2, 1, 16'h0010, 8'h00, 16'h0000, 0});
      tv.push_back('{3'd0, 0, 16'h0000, 8'h00, 16'h0010, 0});
      tv.push_back('{3'd6, 1, 16'h0001, 8'h00, 16'h0000, 0});
      tv.push_back('{3'd6, 0, 16'h0000, 8'h00, 16'h0001, 1});
      tv.push_back('{3'd3, 1, 16'h0020, 8'h00, 16'h0010, 1});
      tv.push_back('{3'd5, 1, 16'h0021, 8'h00, 16'h0000, 0});
      tv.push_back('{3'd1, 0, 16'h0000, 8'h00, 16'h0020, 0});
      tv.push_back('{3'd3, 1, 16'h0000, 8'h00, 16'h0020, 0});
      tv.push_back('{3'd1, 0, 16'h0000, 8'h00, 16'h0000, 0});
      tv.push_back('{3'd7, 1, 16'hFFFF, 8'h00, 16'h0000, 0});
      tv.push_back('{3'd7, 0, 16'h0000, 8'h00, 16'h0000, 0});
      tv.push_back('{3'd2, 1, 16'hFF00, 8'h00, 16'h0010, 0});
      tv.push_back('{3'd2, 0, 16'h0000, 8'h00, 16'h0000, 0});

      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("reset rd", readdata, 16'h0000);
      check("reset irq", {15'h0, irq}, 16'h0000);
      reset = 1'b0;

      foreach (tv[k]) begin
         step(tv[k].a, tv[k].wr, !tv[k].wr, tv[k].wd, tv[k].iv, $sformatf("vec%0d", k));
         check($sformatf("vec%0d rd", k), readdata, tv[k].rd);
         check($sformatf("vec%0d irq", k), {15'h0, irq}, {15'h0, tv[k].irq});
      end

      // async reset in the middle of an active level interrupt
      step(3'd2, 1, 0, 16'h0001, 8'h01, "ar0");
      step(3'd2, 0, 1, 16'h0000, 8'h01, "ar1");
      step(3'd2, 0, 1, 16'h0000, 8'h01, "ar2");
      check("ar pre rd", readdata, 16'h0001);
      check("ar pre irq", {15'h0, irq}, 16'h0001);
      #2;
      reset = 1'b1;
      #1;
      check("async rd", readdata, 16'h0000);
      check("async irq", {15'h0, irq}, 16'h0000);
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
      step(3'd2, 0, 1, 16'h0000, 8'h01, "post0");
      check("post mask", readdata, 16'h0000);
      step(3'd6, 0, 1, 16'h0000, 8'h01, "post1");
      check("post ctrl", readdata, 16'h0000);

      for (int k = 0; k < 600; k++) begin
         bit cs, wn;
         logic [7:0] iv;
         cs = ($urandom_range(0, 3) != 0);
         wn = ($urandom_range(0, 2) != 0);
         iv = ($urandom_range(0, 3) == 0) ? 8'($urandom) : irq_in;
         step(3'($urandom), cs, wn, 16'($urandom), iv, $sformatf("rnd%0d", k));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
